mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port synchronous word memory between two requesters: instruction fetch (IF) and load/store data (D).
- Accepts at most one access at a time and tracks it for MEM_LAT cycles, then returns read data or a write acknowledge to the requester that issued it.
- Drives the pipeline stall line E.
- Sits between the CPU datapath and the memory array, replacing the ad-hoc fetch/data muxing in the memory wrapper.

Parameters:
- ADDR_W, 30: word-address width.
- DATA_W, 32: data width.
- MEM_LAT, 1: cycles from issue to read data valid. Legal range 1..4; an elaboration error is raised outside this range.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request valid.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data valid or store acknowledge.
- d_rdata  out  DATA_W  load data; 0 for a store acknowledge.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- E  out  1  stall to the CPU.

Behaviour:
- Handshake is valid/ready: a transfer occurs in a cycle where req && gnt.
  - The requester holds req, addr, we and wdata stable until gnt.
  - It may present a new request in the cycle after gnt.
- FSM states: IDLE, BUSY. A down-counter cnt (width 2) and an owner flag own (0 = IF, 1 = D) are registered.
- Issue is allowed when state == IDLE, or when state == BUSY and cnt == 0 (the completion cycle, giving back-to-back issue).
- When issue is allowed and any req is high:
  - Grant exactly one requester; gnt is combinational, in the same cycle as req.
  - mem_en = 1; mem_we = d_we if D is granted, else 0.
  - mem_addr and mem_wdata are muxed from the granted requester.
  - Next state: BUSY, cnt = MEM_LAT-1, own = granted requester.
- Arbitration: round-robin with a last-grant pointer lg.
  - If both requesters request, grant the one not equal to lg.
  - If one requests, grant it. lg updates on every grant.
- Completion: in BUSY with cnt == 0:
  - Assert rvalid of own for one cycle.
  - rdata = mem_rdata for reads; d_rdata = 0 for stores.
  - The other requester's rvalid is 0 and its rdata is 0.
  - If no new issue occurs in this cycle, next state is IDLE.
- In BUSY with cnt != 0: decrement cnt; no gnt; mem_en = 0.
- When not issuing: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Stall: E = (if_req & ~if_gnt) | (d_req & ~d_gnt) | (state == BUSY & ~(cnt == 0)).
  - In the completion cycle E drops unless some request is left ungranted.
- Simultaneous events:
  - Completion and a new issue in the same cycle are both legal.
  - If the completion owner re-requests while the other requester is also waiting, the other wins (round-robin).
- Latency:
  - MEM_LAT == 1: throughput is one access per cycle, rvalid the cycle after gnt.
  - Otherwise: one access per MEM_LAT cycles.
- Reset (takes effect even mid-access):
  - state = IDLE, cnt = 0, own = 0, lg = D, so IF wins the first conflict.
  - An outstanding access is dropped: no rvalid is produced after reset.
  - All gnt/rvalid/mem_* outputs = 0 and E = 0 during the reset cycle.
- Address wrap is not handled here; the full ADDR_W address is passed through unchanged.

Decomposition:
- Shared package cpu_mem_pkg:
  - State encoding IDLE = 1'b0, BUSY = 1'b1.
  - Requester IDs REQ_IF = 1'b0, REQ_D = 1'b1.
  - MEM_LAT_MAX = 4.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], lg. Outputs: one-hot gnt[1:0].

Test Plan:
- Reset, then a single fetch: if_req = 1, if_addr = 0x10, MEM_LAT = 1, memory holds 0x2002000A.
  - if_gnt and mem_en in cycle 0 with mem_addr = 0x10.
  - if_rvalid = 1 and if_rdata = 0x2002000A in cycle 1.
  - E = 0 in cycle 1.
- Conflict after reset: if_req and d_req (load, 0x40) both high.
  - IF is granted first; D is granted in the IF completion cycle.
  - E = 1 until d_rvalid; d_rdata = mem[0x40].
- Store: d_we = 1, d_addr = 0x8, d_wdata = 0xDEADBEEF.
  - mem_we = 1 with matching addr/data.
  - d_rvalid one cycle later with d_rdata = 0.
  - A readback load returns 0xDEADBEEF.
- MEM_LAT = 3 with continuous if_req: gnt every 3rd cycle; E high for 2 of every 3 cycles; no rvalid outside the completion cycles.
- Both requesters held high for 8 cycles with MEM_LAT = 1: grants alternate IF, D, IF, D…; neither is starved.
- rst asserted one cycle after a grant with MEM_LAT = 3: no rvalid ever appears for that access; the first post-reset conflict grants IF.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory port arbiter:
// FSM encoding, requester ids and the latency bound.
package cpu_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester
// that did not win last time gets the one-hot grant.
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       lg_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (lg_i == REQ_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch
// and load/store, tracking a single access for MEM_LAT cycles.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              E
);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LAT must be 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_e     state_q;
    logic [1:0] cnt_q;
    logic       own_q;
    logic       lg_q;
    logic       we_q;

    logic       done;
    logic       cpl;
    logic       can_issue;
    logic       issue;
    logic       own_d;
    logic       we_d;
    logic [1:0] req;
    logic [1:0] gnt;

    // The completion cycle doubles as an issue slot.
    assign done      = (state_q == BUSY) && (cnt_q == 2'd0);
    assign can_issue = !rst && ((state_q == IDLE) || done);
    assign req       = {d_req, if_req} & {2{can_issue}};

    rr_arb2 u_arb (
        .req_i (req),
        .lg_i  (lg_q),
        .gnt_o (gnt)
    );

    assign issue = |gnt;
    assign own_d = gnt[REQ_D];
    assign we_d  = gnt[REQ_D] & d_we;

    assign if_gnt    = gnt[REQ_IF];
    assign d_gnt     = gnt[REQ_D];
    assign mem_en    = issue;
    assign mem_we    = we_d;
    assign mem_addr  = gnt[REQ_D]  ? d_addr  :
                       gnt[REQ_IF] ? if_addr : '0;
    assign mem_wdata = gnt[REQ_D]  ? d_wdata : '0;

    assign cpl       = done & ~rst;
    assign if_rvalid = cpl & (own_q == REQ_IF);
    assign d_rvalid  = cpl & (own_q == REQ_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid & ~we_q) ? mem_rdata : '0;

    assign E = ~rst & ((if_req & ~if_gnt) |
                       (d_req & ~d_gnt) |
                       ((state_q == BUSY) && (cnt_q != 2'd0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            own_q   <= REQ_IF;
            lg_q    <= REQ_D;
            we_q    <= 1'b0;
        end else if (issue) begin
            state_q <= BUSY;
            cnt_q   <= CNT_INIT;
            own_q   <= own_d;
            lg_q    <= own_d;
            we_q    <= we_d;
        end else if (state_q == BUSY) begin
            if (cnt_q == 2'd0) begin
                state_q <= IDLE;
            end else begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps on MEM_LAT=1 and
// MEM_LAT=3 instances plus a randomized run against a timing model.
module tb_mem_port_arbiter;

    localparam int LA = 1;
    localparam logic [31:0] GARB = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst;
    logic mem_load;

    always #5 clk = ~clk;

    logic        a_if_req, a_d_req, a_d_we;
    logic [29:0] a_if_addr, a_d_addr;
    logic [31:0] a_d_wdata;
    logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
    logic [31:0] a_if_rdata, a_d_rdata;
    logic        a_mem_en, a_mem_we, a_E;
    logic [29:0] a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata;

    logic        b_if_req, b_d_req, b_d_we;
    logic [29:0] b_if_addr, b_d_addr;
    logic [31:0] b_d_wdata;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
    logic [31:0] b_if_rdata, b_d_rdata;
    logic        b_mem_en, b_mem_we, b_E;
    logic [29:0] b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr),
        .d_wdata(a_d_wdata), .d_gnt(a_d_gnt),
        .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .E(a_E)
    );

    mem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_gnt(b_d_gnt),
        .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .E(b_E)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 32'h2002_000A;
        return {a, ~a, a ^ 8'h3C, 8'h77};
    endfunction

    // Memory arrays with MEM_LAT-cycle read pipelines.
    logic [31:0] a_mem [0:255];
    logic [31:0] b_mem [0:255];
    logic [31:0] b_p0, b_p1, b_p2;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) a_mem[i] <= init_val(8'(i));
        end else if (a_mem_en && a_mem_we) begin
            a_mem[a_mem_addr[7:0]] <= a_mem_wdata;
        end
        a_mem_rdata <= (a_mem_en && !a_mem_we) ? a_mem[a_mem_addr[7:0]] : GARB;
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) b_mem[i] <= init_val(8'(i));
        end else if (b_mem_en && b_mem_we) begin
            b_mem[b_mem_addr[7:0]] <= b_mem_wdata;
        end
        b_p0 <= (b_mem_en && !b_mem_we) ? b_mem[b_mem_addr[7:0]] : GARB;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end

    assign b_mem_rdata = b_p2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the randomized run.
    logic [31:0] ref_mem [0:255];
    bit          pend, p_who, p_we, m_lg;
    logic [31:0] p_rdata;
    int          p_due, cyc;
    bit          ifp, dp, g_if, g_d, done_m, free_m;
    logic [7:0]  idx;

    initial begin
        rst = 1'b1;
        mem_load = 1'b1;
        a_if_req = 1'b1; a_if_addr = 30'h10;
        a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;

        @(negedge clk);
        chk("rst_if_gnt", a_if_gnt, 0);
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_E", a_E, 0);
        chk("rst_rvalid", {a_d_rvalid, a_if_rvalid}, 0);
        chk("rst_b_out", {b_mem_en, b_E, b_if_gnt, b_d_gnt}, 0);

        // single fetch
        tick(); rst = 1'b0; mem_load = 1'b0;
        @(negedge clk);
        chk("f_if_gnt", a_if_gnt, 1);
        chk("f_mem_en", a_mem_en, 1);
        chk("f_mem_we", a_mem_we, 0);
        chk("f_mem_addr", a_mem_addr, 32'h10);
        tick(); a_if_req = 1'b0;
        @(negedge clk);
        chk("f_if_rvalid", a_if_rvalid, 1);
        chk("f_if_rdata", a_if_rdata, 32'h2002_000A);
        chk("f_E", a_E, 0);

        // conflict right after reset
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        a_if_req = 1'b1; a_if_addr = 30'h24;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 30'h40;
        @(negedge clk);
        chk("c_if_gnt", a_if_gnt, 1);
        chk("c_d_gnt0", a_d_gnt, 0);
        chk("c_E0", a_E, 1);
        tick(); a_if_req = 1'b0;
        @(negedge clk);
        chk("c_if_rvalid", a_if_rvalid, 1);
        chk("c_if_rdata", a_if_rdata, init_val(8'h24));
        chk("c_d_gnt1", a_d_gnt, 1);
        tick(); a_d_req = 1'b0;
        @(negedge clk);
        chk("c_d_rvalid", a_d_rvalid, 1);
        chk("c_d_rdata", a_d_rdata, init_val(8'h40));
        chk("c_E2", a_E, 0);

        // store then readback load
        tick();
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 30'h8;
        a_d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("s_d_gnt", a_d_gnt, 1);
        chk("s_mem_we", a_mem_we, 1);
        chk("s_mem_addr", a_mem_addr, 32'h8);
        chk("s_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        tick(); a_d_we = 1'b0;
        @(negedge clk);
        chk("s_ack_rvalid", a_d_rvalid, 1);
        chk("s_ack_rdata", a_d_rdata, 0);
        chk("s_ld_gnt", a_d_gnt, 1);
        tick(); a_d_req = 1'b0;
        @(negedge clk);
        chk("s_rb_rvalid", a_d_rvalid, 1);
        chk("s_rb_rdata", a_d_rdata, 32'hDEAD_BEEF);

        // both held high: strict alternation starting with IF
        tick();
        a_if_req = 1'b1; a_if_addr = 30'h30;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 30'h31;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("alt_if_gnt", a_if_gnt, 32'(i % 2 == 0));
            chk("alt_d_gnt", a_d_gnt, 32'(i % 2 == 1));
            if (i > 0)
                chk("alt_rvalid", {a_d_rvalid, a_if_rvalid},
                    (i % 2 == 1) ? 32'b01 : 32'b10);
            tick();
        end
        a_if_req = 1'b0; a_d_req = 1'b0;

        // randomized run against the reference model
        tick(); rst = 1'b1; mem_load = 1'b1;
        tick(); rst = 1'b0; mem_load = 1'b0;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_val(8'(k));
        m_lg = 1'b1; pend = 1'b0; cyc = 0; ifp = 1'b0; dp = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!ifp && $urandom_range(0, 1) == 1) begin
                ifp = 1'b1;
                a_if_addr = 30'($urandom_range(0, 255));
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1'b1;
                a_d_we = 1'($urandom_range(0, 1));
                a_d_addr = 30'($urandom_range(0, 255));
                a_d_wdata = $urandom;
            end
            a_if_req = ifp;
            a_d_req = dp;
            @(negedge clk);
            done_m = pend && (cyc == p_due);
            free_m = !pend || done_m;
            g_if = 1'b0; g_d = 1'b0;
            if (free_m && ifp && dp) begin
                g_if = m_lg; g_d = !m_lg;
            end else if (free_m) begin
                g_if = ifp; g_d = dp;
            end
            chk("rnd_if_gnt", a_if_gnt, g_if);
            chk("rnd_d_gnt", a_d_gnt, g_d);
            chk("rnd_mem_en", a_mem_en, g_if | g_d);
            chk("rnd_mem_we", a_mem_we, g_d && a_d_we);
            chk("rnd_mem_addr", a_mem_addr,
                g_d ? a_d_addr : (g_if ? a_if_addr : 30'd0));
            chk("rnd_mem_wdata", a_mem_wdata, g_d ? a_d_wdata : 32'd0);
            chk("rnd_if_rvalid", a_if_rvalid, done_m && !p_who);
            chk("rnd_d_rvalid", a_d_rvalid, done_m && p_who);
            chk("rnd_E", a_E,
                (ifp && !g_if) || (dp && !g_d) || (pend && cyc < p_due));
            if (done_m) begin
                chk("rnd_if_rdata", a_if_rdata, p_who ? 32'd0 : p_rdata);
                chk("rnd_d_rdata", a_d_rdata, p_who ? p_rdata : 32'd0);
                pend = 1'b0;
            end
            if (g_if || g_d) begin
                pend = 1'b1;
                p_who = g_d;
                p_we = g_d && a_d_we;
                idx = g_d ? a_d_addr[7:0] : a_if_addr[7:0];
                p_rdata = p_we ? 32'd0 : ref_mem[idx];
                if (p_we) ref_mem[idx] = a_d_wdata;
                p_due = cyc + LA;
                m_lg = g_d;
            end
            cyc++;
            tick();
            if (g_if) ifp = 1'b0;
            if (g_d) dp = 1'b0;
        end
        a_if_req = 1'b0; a_d_req = 1'b0;

        // MEM_LAT=3 with continuous fetch
        tick();
        b_if_req = 1'b1; b_if_addr = 30'h20;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("l3_gnt", b_if_gnt, 32'(i % 3 == 0));
            chk("l3_E", b_E, 32'(i % 3 != 0));
            chk("l3_rvalid", b_if_rvalid, 32'(i % 3 == 0 && i > 0));
            if (i % 3 == 0 && i > 0)
                chk("l3_rdata", b_if_rdata, init_val(8'(8'h20 + i / 3 - 1)));
            tick();
            if (i % 3 == 0) b_if_addr = b_if_addr + 30'd1;
        end
        b_if_req = 1'b0;
        @(negedge clk);
        chk("l3_last_rvalid", b_if_rvalid, 1);
        chk("l3_last_rdata", b_if_rdata, init_val(8'h22));
        chk("l3_last_E", b_E, 0);

        // reset one cycle after a grant drops the access
        tick();
        b_if_req = 1'b1; b_if_addr = 30'h35;
        @(negedge clk);
        chk("r_gnt", b_if_gnt, 1);
        tick(); b_if_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("r_rst_E", b_E, 0);
        chk("r_rst_rvalid", b_if_rvalid, 0);
        chk("r_rst_en", b_mem_en, 0);
        tick(); rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("r_no_rvalid", {b_d_rvalid, b_if_rvalid}, 0);
            chk("r_no_E", b_E, 0);
            tick();
        end
        b_if_req = 1'b1; b_if_addr = 30'h35;
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 30'h36;
        @(negedge clk);
        chk("r_cf_if", b_if_gnt, 1);
        chk("r_cf_d", b_d_gnt, 0);
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 1) b_if_req = 1'b0;
            if (j == 4) b_d_req = 1'b0;
            @(negedge clk);
            chk("r_d_gnt", b_d_gnt, 32'(j == 3));
            chk("r_d_rvalid", b_d_rvalid, 32'(j == 6));
        end
        chk("r_d_rdata", b_d_rdata, init_val(8'h36));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
